pattern_history_table: RTL and testbench
========================================

// Module: pattern_history_table
// PURPOSE
//  Second level of the two-level local branch predictor. Holds 2**HISTORY_LEN saturating
//  counters indexed by the per-branch history from the local history table. Read port gives
//  the taken/not-taken prediction for history_read. Update port trains the counter selected
//  by history_write with the resolved outcome through a one-stage registered update pipeline.
//  Forwarding hides that pipeline from readers.
// PARAMETERS
//  HISTORY_LEN  10  index width; table depth = 2**HISTORY_LEN entries
//  CTR_BITS      2  width of each saturating counter (>=2)
//  INIT_CTR      1  reset value of every counter (1 = weakly not-taken for CTR_BITS=2)
// PORTS
//  clk              in   1            single clock, all state on rising edge
//  reset            in   1            synchronous, active-high
//  history_read     in   HISTORY_LEN  prediction index (LHT history_read)
//  prediction       out  1            1 = predict taken; MSB of effective counter
//  counter_read     out  CTR_BITS     effective counter value at history_read
//  update_valid     in   1            resolved branch present this cycle
//  history_write    in   HISTORY_LEN  update index (LHT history_write, pre-shift history)
//  taken_not_taken  in   1            resolved outcome, 1 = taken
//  update_pending   out  1            stage register holds an update not yet committed
// BEHAVIOUR
//  - Storage: 2**HISTORY_LEN counters of CTR_BITS in flops. Stage register {upd_v, upd_idx, upd_taken}.
//  - Reset (edge with reset=1): every counter <= INIT_CTR, upd_v <= 0. After reset:
//    update_pending=0, counter_read=INIT_CTR, prediction=INIT_CTR[CTR_BITS-1] (0 at defaults).
//  - reset overrides update_valid and any pending commit. A pending update at the reset edge is discarded.
//  - Update cycle N (update_valid=1): edge ending N captures upd_v=1, upd_idx=history_write,
//    upd_taken=taken_not_taken. update_pending=1 during N+1.
//  - Commit in cycle N+1 (upd_v=1): edge ending N+1 writes ctr[upd_idx] <= sat(ctr[upd_idx]):
//    taken: +1, saturating at 2**CTR_BITS-1. not taken: -1, saturating at 0.
//    No wrap-around, ever. Arithmetic uses CTR_BITS+1 bits internally.
//  - upd_v is reloaded every edge from update_valid. Back-to-back updates (any index, including
//    the same index) are accepted every cycle with no stall.
//    The commit of update k and the capture of update k+1 share an edge. Update k+1 computes from
//    the array in the following cycle, so every outcome is applied exactly once, in order.
//  - Read is combinational from the array plus forwarding:
//    if upd_v && upd_idx==history_read, counter_read = sat(ctr[upd_idx]) (the value being committed);
//    else counter_read = ctr[history_read].
//    prediction = counter_read[CTR_BITS-1].
//  - update_valid in the same cycle as a read of the same index does not affect that cycle's read.
//    The new value is visible from the next cycle (via forwarding), i.e. a 1-cycle read-after-update latency.
//  - No X propagation: outputs fully defined from the first post-reset cycle.
//    Indices are always in range by construction (full 2**HISTORY_LEN table).
// TESTING
//  1 Reset then read idx 0, 0x3FF, 0x155 -> counter_read=1, prediction=0, update_pending=0.
//  2 Four consecutive taken updates to idx 0x2A -> reads in the cycle after each update show 2,3,3,3.
//    Prediction flips to 1 after the first.
//    Then five not-taken updates -> 2,1,0,0,0 (saturation at both ends).
//  3 Update idx 0x10 taken in cycle N while reading 0x10 -> read in N = 1.
//    Read in N+1 = 2 (forwarded, update_pending=1). Read in N+2 = 2 from array (update_pending=0).
//  4 Interleave updates to 0x01 (T) and 0x02 (NT) every cycle for 6 cycles -> ctr[0x01]=3, ctr[0x02]=0.
//    Untouched idx 0x03 remains 1.
//  5 Assert reset in the cycle after an update to 0x05 (update_pending=1).
//    Result: ctr[0x05]=1 after reset, update_pending=0, no late commit.
//  6 Random update/read streams (10k cycles) vs. a behavioural model with 1-cycle delayed commit plus forwarding.
//    All counter_read and prediction values match.

Source files
------------

// File: rtl/pattern_history_table.sv
// pattern_history_table: second level of a two-level local branch predictor.
// Holds 2**HISTORY_LEN saturating counters indexed by per-branch local history.
//
// Ports:
//   clk              clock; all state changes on the rising edge
//   reset            synchronous, active-high; restores every counter to INIT_CTR
//   history_read     prediction index
//   prediction       1 = predict taken (MSB of the effective counter)
//   counter_read     effective counter value at history_read (forwarded if committing)
//   update_valid     a resolved branch is presented this cycle
//   history_write    index of the counter to train
//   taken_not_taken  resolved outcome, 1 = taken
//   update_pending   stage register holds an update that commits at the next edge
`timescale 1ns / 1ps

module pattern_history_table #(
  parameter int unsigned HISTORY_LEN = 10,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned INIT_CTR    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [HISTORY_LEN-1:0] history_read,
  output logic                   prediction,
  output logic [CTR_BITS-1:0]    counter_read,
  input  logic                   update_valid,
  input  logic [HISTORY_LEN-1:0] history_write,
  input  logic                   taken_not_taken,
  output logic                   update_pending
);

  localparam int unsigned       Depth   = 2 ** HISTORY_LEN;
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(INIT_CTR);
  localparam logic [CTR_BITS-1:0] CtrMax  = '1;

  logic [CTR_BITS-1:0]    ctr_q [Depth];
  logic                   upd_v_q;
  logic [HISTORY_LEN-1:0] upd_idx_q;
  logic                   upd_taken_q;
  logic [CTR_BITS-1:0]    commit_val;

  // One extra bit catches overflow on increment and underflow on decrement, so the
  // counter clamps at either end instead of wrapping.
  function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] cur,
                                                   input logic                taken);
    logic [CTR_BITS:0] wide;
    logic [CTR_BITS-1:0] res;
    if (taken) begin
      wide = {1'b0, cur} + 1'b1;
      res  = wide[CTR_BITS] ? CtrMax : wide[CTR_BITS-1:0];
    end else begin
      wide = {1'b0, cur} - 1'b1;
      res  = wide[CTR_BITS] ? '0 : wide[CTR_BITS-1:0];
    end
    return res;
  endfunction

  // Value being written back this cycle; also the forwarding source for readers.
  assign commit_val = sat_step(ctr_q[upd_idx_q], upd_taken_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q       <= '{default: CtrInit};
      upd_v_q     <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      // Commit of the staged update and capture of the next one share this edge;
      // the next one reads the array only after this write has landed.
      if (upd_v_q) begin
        ctr_q[upd_idx_q] <= commit_val;
      end
      upd_v_q     <= update_valid;
      upd_idx_q   <= history_write;
      upd_taken_q <= taken_not_taken;
    end
  end

  always_comb begin
    counter_read = ctr_q[history_read];
    if (upd_v_q && (upd_idx_q == history_read)) begin
      counter_read = commit_val;
    end
  end

  assign prediction     = counter_read[CTR_BITS-1];
  assign update_pending = upd_v_q;

endmodule

// File: tb/tb_pattern_history_table.sv
`timescale 1ns / 1ps

module tb_pattern_history_table;

  localparam int HL    = 10;
  localparam int DEPTH = 1 << HL;

  logic          clk;
  logic          reset;
  logic [HL-1:0] history_read;
  logic          prediction;
  logic [1:0]    counter_read;
  logic          update_valid;
  logic [HL-1:0] history_write;
  logic          taken_not_taken;
  logic          update_pending;

  pattern_history_table #(
    .HISTORY_LEN(HL),
    .CTR_BITS   (2),
    .INIT_CTR   (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .history_read   (history_read),
    .prediction     (prediction),
    .counter_read   (counter_read),
    .update_valid   (update_valid),
    .history_write  (history_write),
    .taken_not_taken(taken_not_taken),
    .update_pending (update_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          upd;
    logic [HL-1:0] widx;
    logic          taken;
    logic [HL-1:0] ridx;
    logic          chk;
    int            exp_ctr;
    logic          exp_pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic upd, input int widx,
                              input logic taken, input int ridx, input logic chk,
                              input int exp_ctr, input logic exp_pend);
    vec_t v;
    v.rst      = rst;
    v.upd      = upd;
    v.widx     = HL'(widx);
    v.taken    = taken;
    v.ridx     = HL'(ridx);
    v.chk      = chk;
    v.exp_ctr  = exp_ctr;
    v.exp_pend = exp_pend;
    return v;
  endfunction

  // Behavioural model: logical counter values as seen by a reader in the current cycle.
  // An update presented in cycle N becomes visible in N+1; reset drops everything.
  int eff[DEPTH];
  bit pend_m;

  function automatic int sat(input int c, input bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic model_edge(input bit rst, input bit upd, input int w, input bit t);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) eff[i] = 1;
      pend_m = 1'b0;
    end else begin
      if (upd) eff[w] = sat(eff[w], t);
      pend_m = upd;
    end
  endtask

  initial begin
    reset           = 1'b1;
    update_valid    = 1'b0;
    history_write   = '0;
    taken_not_taken = 1'b0;
    history_read    = '0;

    // Directed sequences: one record per cycle; outputs checked before the closing edge.
    tbl.push_back(mk(1, 0, 0,     0, 0,     0, 0, 0));
    // reset state
    tbl.push_back(mk(0, 0, 0,     0, 0,     1, 1, 0));
    tbl.push_back(mk(0, 0, 0,     0, 'h3FF, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,     0, 'h155, 1, 1, 0));
    // four taken then five not-taken to 0x2A
    tbl.push_back(mk(0, 1, 'h2A,  1, 'h2A,  1, 1, 0));
    tbl.push_back(mk(0, 1, 'h2A,  1, 'h2A,  1, 2, 1));
    tbl.push_back(mk(0, 1, 'h2A,  1, 'h2A,  1, 3, 1));
    tbl.push_back(mk(0, 1, 'h2A,  1, 'h2A,  1, 3, 1));
    tbl.push_back(mk(0, 1, 'h2A,  0, 'h2A,  1, 3, 1));
    tbl.push_back(mk(0, 1, 'h2A,  0, 'h2A,  1, 2, 1));
    tbl.push_back(mk(0, 1, 'h2A,  0, 'h2A,  1, 1, 1));
    tbl.push_back(mk(0, 1, 'h2A,  0, 'h2A,  1, 0, 1));
    tbl.push_back(mk(0, 1, 'h2A,  0, 'h2A,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 'h2A,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 'h2A,  1, 0, 0));
    // read-after-update latency on 0x10
    tbl.push_back(mk(0, 1, 'h10,  1, 'h10,  1, 1, 0));
    tbl.push_back(mk(0, 0, 0,     0, 'h10,  1, 2, 1));
    tbl.push_back(mk(0, 0, 0,     0, 'h10,  1, 2, 0));
    // interleaved 0x01 taken / 0x02 not-taken, watching 0x03
    tbl.push_back(mk(0, 1, 'h01,  1, 'h03,  1, 1, 0));
    tbl.push_back(mk(0, 1, 'h02,  0, 'h03,  1, 1, 1));
    tbl.push_back(mk(0, 1, 'h01,  1, 'h03,  1, 1, 1));
    tbl.push_back(mk(0, 1, 'h02,  0, 'h03,  1, 1, 1));
    tbl.push_back(mk(0, 1, 'h01,  1, 'h03,  1, 1, 1));
    tbl.push_back(mk(0, 1, 'h02,  0, 'h03,  1, 1, 1));
    tbl.push_back(mk(0, 0, 0,     0, 'h01,  1, 3, 1));
    tbl.push_back(mk(0, 0, 0,     0, 'h02,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 'h03,  1, 1, 0));
    // reset while an update to 0x05 is pending
    tbl.push_back(mk(0, 1, 'h05,  1, 'h05,  1, 1, 0));
    tbl.push_back(mk(1, 0, 0,     0, 'h05,  1, 2, 1));
    tbl.push_back(mk(0, 0, 0,     0, 'h05,  1, 1, 0));
    tbl.push_back(mk(0, 0, 0,     0, 'h2A,  1, 1, 0));
    tbl.push_back(mk(0, 0, 0,     0, 'h05,  1, 1, 0));
    // reset overrides a same-cycle update
    tbl.push_back(mk(1, 1, 'h07,  1, 'h07,  1, 1, 0));
    tbl.push_back(mk(0, 0, 0,     0, 'h07,  1, 1, 0));

    foreach (tbl[i]) begin
      reset           = tbl[i].rst;
      update_valid    = tbl[i].upd;
      history_write   = tbl[i].widx;
      taken_not_taken = tbl[i].taken;
      history_read    = tbl[i].ridx;
      @(negedge clk);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d counter_read", i), int'(counter_read), tbl[i].exp_ctr);
        check($sformatf("vec%0d prediction", i), int'(prediction), (tbl[i].exp_ctr >= 2) ? 1 : 0);
        check($sformatf("vec%0d update_pending", i), int'(update_pending), int'(tbl[i].exp_pend));
      end
      @(posedge clk);
      #1;
    end

    // Random phase: start from a clean reset so the model is in step.
    reset        = 1'b1;
    update_valid = 1'b0;
    @(posedge clk);
    #1;
    model_edge(1'b1, 1'b0, 0, 1'b0);

    for (int cyc = 0; cyc < 10000; cyc++) begin
      bit rst_r, upd_r, tk_r;
      int w_r, r_r;
      rst_r = ($urandom_range(0, 199) == 0);
      upd_r = ($urandom_range(0, 3) != 0);
      tk_r  = $urandom_range(0, 1);
      w_r   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 2))
        0:       r_r = w_r;
        1:       r_r = $urandom_range(0, 7);
        default: r_r = $urandom_range(0, DEPTH - 1);
      endcase
      reset           = rst_r;
      update_valid    = upd_r;
      history_write   = HL'(w_r);
      taken_not_taken = tk_r;
      history_read    = HL'(r_r);
      @(negedge clk);
      check("rand counter_read", int'(counter_read), eff[r_r]);
      check("rand prediction", int'(prediction), (eff[r_r] >= 2) ? 1 : 0);
      check("rand update_pending", int'(update_pending), int'(pend_m));
      @(posedge clk);
      #1;
      model_edge(rst_r, upd_r, w_r, tk_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
